fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 10'd0, byte address loaded into the PC on reset.
REQ-002 Parameter QDEPTH, default 2, entry count of the fetch queue; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = fetching permitted; 0 = no new fetches, queue keeps draining.
REQ-006 imem_addr  output  10  byte address to instruction memory, always equal to the PC register.
REQ-007 imem_data  input  32  combinational big-endian word returned by instruction memory for imem_addr.
REQ-008 redirect  input  1  branch/jump taken this cycle; flush queue and load PC.
REQ-009 redirect_pc  input  10  target byte address accompanying redirect.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_data  output  32  instruction word at queue head.
REQ-012 inst_pc  output  10  byte address the queue-head instruction was fetched from.
REQ-013 inst_ready  input  1  decode accepts the head this cycle.
REQ-014 misalign  output  1  registered one-cycle pulse; last redirect_pc had nonzero bits [1:0].

Function
REQ-015 FSM states: IDLE, RUN; IDLE->RUN on enable=1, RUN->IDLE on enable=0, redirect honoured in both states.
REQ-016 Push condition: state RUN, enable=1, redirect=0, and (count<QDEPTH or pop this cycle).
REQ-017 On push, {PC, imem_data} is written at queue tail and PC <= PC+4 modulo 1024 (0x3FC wraps to 0x000).
REQ-018 No push leaves PC unchanged and imem_addr stable.
REQ-019 Pop occurs when inst_valid=1 and inst_ready=1; head advances in FIFO order.
REQ-020 inst_valid = (count!=0) and redirect=0, so no handshake completes in a redirect cycle.
REQ-021 Push and pop in the same cycle keep count unchanged; legal at full and at count=1.
REQ-022 Latency: a word fetched in cycle t is presented on inst_data no earlier than cycle t+1.
REQ-023 inst_data/inst_pc are don't-care when inst_valid=0 but are driven from the head slot, never X after reset.
REQ-024 Redirect: count <= 0, PC <= {redirect_pc[9:2],2'b00}, no push that cycle; redirect has priority over all other events.
REQ-025 misalign <= 1 in the cycle after a redirect with redirect_pc[1:0]!=0, else 0.
REQ-026 Back-to-back redirects: each cycle's redirect_pc wins; the first fetch occurs in the cycle after the last redirect.
REQ-027 With enable=0 the queue drains normally and PC holds; re-enable resumes at held PC with no skipped or duplicate address.
REQ-028 Full queue with inst_ready=0: no push, PC holds, queue contents and head outputs stable.
REQ-029 Sustained throughput: one instruction per cycle when inst_ready=1 continuously and no redirect.

Reset
REQ-030 While reset=1 (asynchronously on assertion): PC=RESET_PC, imem_addr=RESET_PC, count=0, inst_valid=0, misalign=0, FSM=IDLE, queue slots cleared to 0.
REQ-031 Reset asserted mid-fetch or mid-redirect discards all queued entries; no push occurs on the deasserting edge.
REQ-032 First push after reset is at the first rising edge with reset=0, FSM in RUN and enable=1.

Verification
REQ-033 Reset, enable=1, inst_ready=1, memory words W0..W3 at 0x000..0x00C -> inst_pc 0x000,0x004,0x008,0x00C on consecutive cycles from cycle 2 with matching inst_data.
REQ-034 inst_ready=0 for 5 cycles, QDEPTH=2 -> count saturates at 2, imem_addr holds 0x008, head stays 0x000; release -> 0x000,0x004,0x008 in order, no gaps.
REQ-035 Redirect to 0x020 while queue full -> inst_valid=0 that cycle, next cycle imem_addr=0x020, following cycle inst_pc=0x020.
REQ-036 Redirect to 0x013 -> misalign=1 for exactly one cycle, fetch resumes at 0x010.
REQ-037 Redirect to 0x3F8, run 4 fetches -> inst_pc 0x3F8,0x3FC,0x000,0x004.
REQ-038 Reset pulsed asynchronously between clock edges with 2 entries queued -> inst_valid=0 immediately, imem_addr=RESET_PC, no stale entry after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end. Holds the PC, fetches one word
// per cycle into a small FIFO (QDEPTH entries) and presents the head to
// decode with a valid/ready handshake. Redirects flush the FIFO and reload
// the PC (word-aligned), raising a one-cycle misalign pulse for unaligned
// targets.
module fetch_ctrl #(
  parameter logic [9:0] RESET_PC = 10'd0,
  parameter int         QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [9:0]  redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [9:0]  inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  localparam int         PW      = (QDEPTH == 4) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(QDEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [9:0]    pc_q, pc_d;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          misalign_q, misalign_d;

  logic [9:0]    slot_pc_q   [QDEPTH];
  logic [31:0]   slot_data_q [QDEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;

  // Handshake and push qualification; a redirect blocks both directions.
  always_comb begin
    valid_s = (count_q != 3'd0) && !redirect;
    pop_s   = valid_s && inst_ready;
    push_s  = (state_q == ST_RUN) && enable && !redirect &&
              ((count_q < DEPTH_C) || pop_s);
  end

  // FSM next state: fetching is gated by the state reached on the previous edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointers, occupancy, PC and misalign next state; redirect wins.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = {redirect_pc[9:2], 2'b00};
      count_d    = 3'd0;
      head_d     = '0;
      tail_d     = '0;
      misalign_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push_s) begin
        pc_d   = pc_q + 10'd4;
        tail_d = tail_q + 1'b1;
      end else begin
        pc_d   = pc_q;
        tail_d = tail_q;
      end
      if (pop_s) head_d = head_q + 1'b1;
      else       head_d = head_q;
      count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      count_q    <= 3'd0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      misalign_q <= misalign_d;
    end
  end

  // Queue storage: write {PC, word} at the tail on each push; cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        slot_pc_q[i]   <= 10'd0;
        slot_data_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      slot_pc_q[tail_q]   <= pc_q;
      slot_data_q[tail_q] <= imem_data;
    end else begin
      slot_pc_q[tail_q]   <= slot_pc_q[tail_q];
      slot_data_q[tail_q] <= slot_data_q[tail_q];
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = valid_s;
  assign inst_pc    = slot_pc_q[head_q];
  assign inst_data  = slot_data_q[head_q];
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a
// queue-based reference model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [9:0] RPC = 10'd0;
  localparam int         QD  = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [9:0]  inst_pc;
  logic        inst_ready;
  logic        misalign;

  logic [31:0] mem [0:255];

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] data;
  } ent_t;

  ent_t       q[$];
  logic [9:0] m_pc;
  logic       m_run;
  logic       m_mis;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .misalign(misalign)
  );

  assign imem_data = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = RPC;
    m_run = 1'b0;
    m_mis = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against
  // the model, advance the model, and return at the next falling edge.
  task automatic cycle(input logic en, input logic rdy, input logic rd, input logic [9:0] rpc);
    logic v, pop, push;
    ent_t e;
    enable = en; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    v = (q.size() != 0) && !rd;
    chk("inst_valid", inst_valid, v);
    chk("imem_addr", imem_addr, m_pc);
    chk("misalign", misalign, m_mis);
    if (v) begin
      chk("inst_pc", inst_pc, q[0].pc);
      chk("inst_data", inst_data, q[0].data);
    end
    pop = v && rdy;
    if (rd) begin
      q.delete();
      m_pc  = {rpc[9:2], 2'b00};
      m_mis = (rpc[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      push  = m_run && en && ((q.size() < QD) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc   = m_pc;
        e.data = mem[m_pc / 4];
        q.push_back(e);
        m_pc = 10'((int'(m_pc) + 4) % 1024);
      end
    end
    m_run = en;
    @(negedge clk);
  endtask

  // Reset asserted and released between clock edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_addr", imem_addr, RPC);
    chk("arst_mis", misalign, 1'b0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = 10'd0; inst_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 10'd0);
    reset = 1'b0;

    // Streaming from reset: first word visible two edges after enable.
    cycle(1'b1, 1'b1, 1'b0, 10'd0);
    cycle(1'b1, 1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", inst_valid, 1'b1);
      chk("stream_pc", inst_pc, 10'(i * 4));
      chk("stream_data", inst_data, mem[i]);
      cycle(1'b1, 1'b1, 1'b0, 10'd0);
    end

    // Stall with full queue, then release.
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 10'd0);
    chk("stall_addr", imem_addr, 10'h008);
    chk("stall_head", inst_pc, 10'h000);
    for (int i = 0; i < 3; i++) begin
      chk("release_pc", inst_pc, 10'(i * 4));
      cycle(1'b1, 1'b1, 1'b0, 10'd0);
    end

    // Redirect while full.
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    cycle(1'b1, 1'b1, 1'b1, 10'h020);
    chk("redir_addr", imem_addr, 10'h020);
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    chk("redir_head", inst_pc, 10'h020);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 1'b1, 10'h013);
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_addr", imem_addr, 10'h010);
    cycle(1'b1, 1'b1, 1'b0, 10'd0);
    chk("mis_clear", misalign, 1'b0);
    chk("mis_head", inst_pc, 10'h010);

    // Back-to-back redirects then wrap at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 10'h100);
    cycle(1'b1, 1'b1, 1'b1, 10'h3F8);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 10'd0);

    // Disable: queue drains and PC holds, then resume.
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 10'd0);

    // Asynchronous reset with two entries queued.
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    cycle(1'b1, 1'b0, 1'b0, 10'd0);
    chk("pre_arst_valid", inst_valid, 1'b1);
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 10'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 15) == 0), 10'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
